// File: rtl/datapath_regs.sv
// rtl/datapath_regs.sv - architectural registers, shared bus mux and ALU (optional flags: DATAPATH_FLAGS_EN)
module datapath_regs #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int OPC_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        read_en,
    input  logic [15:0]       write_en,
    input  logic [15:0]       inc_en,
    input  logic [15:0]       clr_en,
    input  logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] im_rdata,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic [ADDR_W-1:0] im_addr,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              dm_we,
    output logic [OPC_W-1:0]  instruction,
    output logic [15:0]       z,
    output logic [DATA_W-1:0] bus_dbg
`ifdef DATAPATH_FLAGS_EN
    ,
    output logic [2:0]        flags
`endif
);

    logic [DATA_W-1:0] r_pc, r_ar, r_ir, r_ac, r_r, r_r1, r_r2, r_r3, r_r4;
    logic [DATA_W-1:0] w_bus;
    logic [DATA_W-1:0] w_alu;
    logic              w_unused;

    // Shared priority for every register: clear, then load, then increment, else hold
    function automatic logic [DATA_W-1:0] f_next(
        input logic [DATA_W-1:0] cur,
        input logic              clr,
        input logic              wr,
        input logic              inc,
        input logic [DATA_W-1:0] load_val
    );
        if (clr)
            return '0;
        else if (wr)
            return load_val;
        else if (inc)
            return cur + {{(DATA_W-1){1'b0}}, 1'b1};
        else
            return cur;
    endfunction

    // Single bus source selected by read_en; unused codes drive zero
    always_comb begin
        w_bus = '0;
        case (read_en)
            4'd1:    w_bus = r_pc;
            4'd2:    w_bus = r_ar;
            4'd4:    w_bus = r_ir;
            4'd5:    w_bus = r_ac;
            4'd6:    w_bus = r_r;
            4'd7:    w_bus = r_r1;
            4'd8:    w_bus = r_r2;
            4'd9:    w_bus = r_r3;
            4'd10:   w_bus = r_r4;
            4'd12:   w_bus = dm_rdata;
            4'd13:   w_bus = im_rdata;
            default: w_bus = '0;
        endcase
    end

    // ALU operates on AC and R; unknown ops pass AC through
    always_comb begin
        w_alu = r_ac;
        case (alu_op)
            3'd1:    w_alu = r_ac + r_r;
            3'd2:    w_alu = r_ac - r_r;
            3'd3:    w_alu = r_ac * r_r;
            3'd4:    w_alu = {r_ac[DATA_W-2:0], 1'b0};
            default: w_alu = r_ac;
        endcase
    end

    // Register file update; AC takes the ALU result over the bus when both loads are requested
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= '0;
            r_ar <= '0;
            r_ir <= '0;
            r_ac <= '0;
            r_r  <= '0;
            r_r1 <= '0;
            r_r2 <= '0;
            r_r3 <= '0;
            r_r4 <= '0;
        end else begin
            r_pc <= f_next(r_pc, clr_en[1],  write_en[1],  inc_en[1],  w_bus);
            r_ar <= f_next(r_ar, clr_en[2],  write_en[2],  inc_en[2],  w_bus);
            r_ir <= f_next(r_ir, clr_en[3],  write_en[3],  inc_en[3],  w_bus);
            r_ac <= f_next(r_ac, clr_en[4],  write_en[4] | write_en[12], inc_en[4],
                           write_en[12] ? w_alu : w_bus);
            r_r  <= f_next(r_r,  clr_en[5],  write_en[5],  inc_en[5],  w_bus);
            r_r4 <= f_next(r_r4, clr_en[7],  write_en[7],  inc_en[7],  w_bus);
            r_r3 <= f_next(r_r3, clr_en[8],  write_en[8],  inc_en[8],  w_bus);
            r_r2 <= f_next(r_r2, clr_en[9],  write_en[9],  inc_en[9],  w_bus);
            r_r1 <= f_next(r_r1, clr_en[10], write_en[10], inc_en[10], w_bus);
        end
    end

`ifdef DATAPATH_FLAGS_EN
    logic [DATA_W:0] w_add_ext, w_sub_ext;
    logic            w_carry, w_ovf;
    logic [2:0]      r_flags;

    // Carry/borrow and signed overflow only meaningful for add and sub
    always_comb begin
        w_add_ext = {1'b0, r_ac} + {1'b0, r_r};
        w_sub_ext = {1'b0, r_ac} - {1'b0, r_r};
        w_carry   = 1'b0;
        w_ovf     = 1'b0;
        if (alu_op == 3'd1) begin
            w_carry = w_add_ext[DATA_W];
            w_ovf   = (r_ac[DATA_W-1] == r_r[DATA_W-1]) && (w_alu[DATA_W-1] != r_ac[DATA_W-1]);
        end else if (alu_op == 3'd2) begin
            w_carry = w_sub_ext[DATA_W];
            w_ovf   = (r_ac[DATA_W-1] != r_r[DATA_W-1]) && (w_alu[DATA_W-1] != r_ac[DATA_W-1]);
        end
    end

    // Flags captured only when the ALU result is written to AC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_flags <= 3'b000;
        else if (write_en[12])
            r_flags <= {w_carry, w_ovf, w_alu[DATA_W-1]};
    end

    assign flags = r_flags;
`endif

    assign im_addr     = r_pc[ADDR_W-1:0];
    assign dm_addr     = r_ar[ADDR_W-1:0];
    assign dm_wdata    = r_ac;
    assign dm_we       = rst_n & write_en[11];
    assign instruction = r_ir[OPC_W-1:0];
    assign z           = {15'd0, (r_ac == '0)};
    assign bus_dbg     = w_bus;

    assign w_unused = &{1'b0, write_en[0], write_en[6], write_en[15:13],
                        inc_en[0], inc_en[6], inc_en[15:11],
                        clr_en[0], clr_en[6], clr_en[15:11],
                        r_ir[DATA_W-1:OPC_W], r_pc[DATA_W-1:ADDR_W], r_ar[DATA_W-1:ADDR_W]};

endmodule

// File: tb/tb_datapath_regs.sv
// tb/tb_datapath_regs.sv - vector table plus hand sequences for datapath_regs
module tb_datapath_regs;

    logic        clk;
    logic        rst_n;
    logic [3:0]  read_en;
    logic [15:0] write_en, inc_en, clr_en;
    logic [2:0]  alu_op;
    logic [15:0] im_rdata, dm_rdata;
    logic [7:0]  im_addr, dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_we;
    logic [5:0]  instruction;
    logic [15:0] z;
    logic [15:0] bus_dbg;
`ifdef DATAPATH_FLAGS_EN
    logic [2:0]  flags;
`endif

    datapath_regs dut (
        .clk(clk), .rst_n(rst_n), .read_en(read_en), .write_en(write_en),
        .inc_en(inc_en), .clr_en(clr_en), .alu_op(alu_op),
        .im_rdata(im_rdata), .dm_rdata(dm_rdata), .im_addr(im_addr),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we),
        .instruction(instruction), .z(z), .bus_dbg(bus_dbg)
`ifdef DATAPATH_FLAGS_EN
        , .flags(flags)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  rd;
        logic [15:0] we;
        logic [15:0] ie;
        logic [15:0] ce;
        logic [2:0]  op;
        logic [15:0] im;
        logic [15:0] dm;
        logic [3:0]  probe;
        logic [15:0] exp_bus;
        logic        exp_z;
        logic [5:0]  exp_instr;
    } vec_t;

    typedef struct packed {
        int          idx;
        logic [15:0] exp_bus;
        logic        exp_z;
        logic [5:0]  exp_instr;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(logic [3:0] rd, logic [15:0] we, logic [15:0] ie, logic [15:0] ce,
                                logic [2:0] op, logic [15:0] im, logic [15:0] dm, logic [3:0] probe,
                                logic [15:0] exp_bus, logic exp_z, logic [5:0] exp_instr);
        vec_t v;
        v = '{rd, we, ie, ce, op, im, dm, probe, exp_bus, exp_z, exp_instr};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        write_en = 16'h0; inc_en = 16'h0; clr_en = 16'h0; alu_op = 3'd0;
    endtask

    // Drive one vector for one edge, then probe a register through the bus
    task automatic apply(input int idx, input vec_t v);
        exp_t e;
        @(negedge clk);
        read_en = v.rd; write_en = v.we; inc_en = v.ie; clr_en = v.ce;
        alu_op = v.op; im_rdata = v.im; dm_rdata = v.dm;
        e = '{idx, v.exp_bus, v.exp_z, v.exp_instr};
        sb.push_back(e);
        @(posedge clk);
        #1;
        idle_inputs();
        read_en = v.probe;
        #1;
        e = sb.pop_front();
        check($sformatf("vec%0d_bus", e.idx), {16'h0, bus_dbg}, {16'h0, e.exp_bus});
        check($sformatf("vec%0d_z", e.idx), {16'h0, z}, {31'h0, e.exp_z});
        check($sformatf("vec%0d_instr", e.idx), {26'h0, instruction}, {26'h0, e.exp_instr});
    endtask

    task automatic run_all();
        foreach (vecs[i]) apply(i, vecs[i]);
        vecs.delete();
    endtask

    int codes[9] = '{1, 2, 4, 5, 6, 7, 8, 9, 10};

    initial begin
        rst_n = 1'b0; read_en = 4'd0; im_rdata = 16'h0; dm_rdata = 16'h0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_z", {16'h0, z}, 32'd1);
        check("rst_dm_we", {31'h0, dm_we}, 32'd0);
        check("rst_instr", {26'h0, instruction}, 32'd0);
        foreach (codes[i]) begin
            read_en = codes[i][3:0];
            #1;
            check($sformatf("rst_bus_code%0d", codes[i]), {16'h0, bus_dbg}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        //          rd     we        ie        ce        op    im        dm        pr    exp      z     ir
        vecs.push_back(mk(4'd13, 16'h0010, 16'h0, 16'h0, 3'd0, 16'h0005, 16'h0, 4'd5, 16'h0005, 1'b0, 6'd0));
        vecs.push_back(mk(4'd13, 16'h0020, 16'h0, 16'h0, 3'd0, 16'h0003, 16'h0, 4'd6, 16'h0003, 1'b0, 6'd0));
        vecs.push_back(mk(4'd0,  16'h1000, 16'h0, 16'h0, 3'd1, 16'h0000, 16'h0, 4'd5, 16'h0008, 1'b0, 6'd0));
        vecs.push_back(mk(4'd13, 16'h0010, 16'h0, 16'h0, 3'd0, 16'h0007, 16'h0, 4'd5, 16'h0007, 1'b0, 6'd0));
        vecs.push_back(mk(4'd13, 16'h0020, 16'h0, 16'h0, 3'd0, 16'h0007, 16'h0, 4'd6, 16'h0007, 1'b0, 6'd0));
        vecs.push_back(mk(4'd0,  16'h1000, 16'h0, 16'h0, 3'd2, 16'h0000, 16'h0, 4'd5, 16'h0000, 1'b1, 6'd0));
        vecs.push_back(mk(4'd13, 16'h0008, 16'h0, 16'h0, 3'd0, 16'h0013, 16'h0, 4'd4, 16'h0013, 1'b1, 6'd19));
        vecs.push_back(mk(4'd12, 16'h0002, 16'h0, 16'h0, 3'd0, 16'h0000, 16'hFFFF, 4'd1, 16'hFFFF, 1'b1, 6'd19));
        vecs.push_back(mk(4'd0,  16'h0000, 16'h0002, 16'h0, 3'd0, 16'h0000, 16'h0, 4'd1, 16'h0000, 1'b1, 6'd19));
        vecs.push_back(mk(4'd12, 16'h0002, 16'h0, 16'h0, 3'd0, 16'h0000, 16'hFFFF, 4'd1, 16'hFFFF, 1'b1, 6'd19));
        vecs.push_back(mk(4'd13, 16'h0002, 16'h0002, 16'h0, 3'd0, 16'h0040, 16'h0, 4'd1, 16'h0040, 1'b1, 6'd19));
        vecs.push_back(mk(4'd13, 16'h0010, 16'h0, 16'h0, 3'd0, 16'h8001, 16'h0, 4'd5, 16'h8001, 1'b0, 6'd19));
        vecs.push_back(mk(4'd0,  16'h1000, 16'h0, 16'h0, 3'd4, 16'h0000, 16'h0, 4'd5, 16'h0002, 1'b0, 6'd19));
        vecs.push_back(mk(4'd13, 16'h0020, 16'h0, 16'h0, 3'd0, 16'h0010, 16'h0, 4'd6, 16'h0010, 1'b0, 6'd19));
        vecs.push_back(mk(4'd13, 16'h0010, 16'h0, 16'h0, 3'd0, 16'h0123, 16'h0, 4'd5, 16'h0123, 1'b0, 6'd19));
        vecs.push_back(mk(4'd0,  16'h1000, 16'h0, 16'h0, 3'd3, 16'h0000, 16'h0, 4'd5, 16'h1230, 1'b0, 6'd19));
        vecs.push_back(mk(4'd0,  16'h1000, 16'h0, 16'h0, 3'd6, 16'h0000, 16'h0, 4'd5, 16'h1230, 1'b0, 6'd19));
        vecs.push_back(mk(4'd13, 16'h1010, 16'h0, 16'h0, 3'd1, 16'h7777, 16'h0, 4'd5, 16'h1240, 1'b0, 6'd19));
        vecs.push_back(mk(4'd0,  16'h1000, 16'h0010, 16'h0, 3'd1, 16'h0000, 16'h0, 4'd5, 16'h1250, 1'b0, 6'd19));
        vecs.push_back(mk(4'd0,  16'h0000, 16'h0010, 16'h0, 3'd0, 16'h0000, 16'h0, 4'd5, 16'h1251, 1'b0, 6'd19));
        vecs.push_back(mk(4'd13, 16'h0010, 16'h0, 16'h0010, 3'd0, 16'h0055, 16'h0, 4'd5, 16'h0000, 1'b1, 6'd19));
        vecs.push_back(mk(4'd13, 16'h0400, 16'h0, 16'h0, 3'd0, 16'h1111, 16'h0, 4'd7, 16'h1111, 1'b1, 6'd19));
        vecs.push_back(mk(4'd13, 16'h0200, 16'h0, 16'h0, 3'd0, 16'h2222, 16'h0, 4'd8, 16'h2222, 1'b1, 6'd19));
        vecs.push_back(mk(4'd13, 16'h0100, 16'h0, 16'h0, 3'd0, 16'h3333, 16'h0, 4'd9, 16'h3333, 1'b1, 6'd19));
        vecs.push_back(mk(4'd13, 16'h0080, 16'h0, 16'h0, 3'd0, 16'h4444, 16'h0, 4'd10, 16'h4444, 1'b1, 6'd19));
        vecs.push_back(mk(4'd0,  16'h0000, 16'h0200, 16'h0, 3'd0, 16'h0000, 16'h0, 4'd8, 16'h2223, 1'b1, 6'd19));
        vecs.push_back(mk(4'd0,  16'h0000, 16'h0, 16'h0080, 3'd0, 16'h0000, 16'h0, 4'd10, 16'h0000, 1'b1, 6'd19));
        vecs.push_back(mk(4'd13, 16'hE041, 16'hE041, 16'hE041, 3'd1, 16'hDEAD, 16'h0, 4'd7, 16'h1111, 1'b1, 6'd19));
        vecs.push_back(mk(4'd0,  16'h0000, 16'h0, 16'h0, 3'd0, 16'h0000, 16'h0, 4'd3, 16'h0000, 1'b1, 6'd19));
        vecs.push_back(mk(4'd0,  16'h0000, 16'h0, 16'h0, 3'd0, 16'h0000, 16'h0, 4'd11, 16'h0000, 1'b1, 6'd19));
        vecs.push_back(mk(4'd0,  16'h0000, 16'h0, 16'h0, 3'd0, 16'h0000, 16'h0, 4'd14, 16'h0000, 1'b1, 6'd19));
        vecs.push_back(mk(4'd0,  16'h0000, 16'h0, 16'h0, 3'd0, 16'h0000, 16'h0, 4'd15, 16'h0000, 1'b1, 6'd19));
        vecs.push_back(mk(4'd0,  16'h0000, 16'h0, 16'h0, 3'd0, 16'h0000, 16'h0, 4'd0, 16'h0000, 1'b1, 6'd19));
        vecs.push_back(mk(4'd13, 16'h0004, 16'h0, 16'h0, 3'd0, 16'h0010, 16'h0, 4'd2, 16'h0010, 1'b1, 6'd19));
        vecs.push_back(mk(4'd13, 16'h0010, 16'h0, 16'h0, 3'd0, 16'h00AA, 16'h0, 4'd5, 16'h00AA, 1'b0, 6'd19));
        run_all();

        check("im_addr", {24'h0, im_addr}, 32'h40);

        // Store: dm_we follows write_en[11] for exactly that cycle
        @(negedge clk);
        read_en = 4'd0; write_en = 16'h0800;
        #1;
        check("st_dm_we", {31'h0, dm_we}, 32'd1);
        check("st_dm_addr", {24'h0, dm_addr}, 32'h10);
        check("st_dm_wdata", {16'h0, dm_wdata}, 32'h00AA);
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        check("st_dm_we_drop", {31'h0, dm_we}, 32'd0);

`ifdef DATAPATH_FLAGS_EN
        vecs.push_back(mk(4'd13, 16'h0010, 16'h0, 16'h0, 3'd0, 16'h7FFF, 16'h0, 4'd5, 16'h7FFF, 1'b0, 6'd19));
        vecs.push_back(mk(4'd13, 16'h0020, 16'h0, 16'h0, 3'd0, 16'h0001, 16'h0, 4'd6, 16'h0001, 1'b0, 6'd19));
        vecs.push_back(mk(4'd0,  16'h1000, 16'h0, 16'h0, 3'd1, 16'h0000, 16'h0, 4'd5, 16'h8000, 1'b0, 6'd19));
        run_all();
        check("flags_add_ovf", {29'h0, flags}, 32'b011);
        vecs.push_back(mk(4'd0,  16'h0000, 16'h0, 16'h0010, 3'd0, 16'h0000, 16'h0, 4'd5, 16'h0000, 1'b1, 6'd19));
        vecs.push_back(mk(4'd0,  16'h1000, 16'h0, 16'h0, 3'd2, 16'h0000, 16'h0, 4'd5, 16'hFFFF, 1'b0, 6'd19));
        run_all();
        check("flags_sub_borrow", {29'h0, flags}, 32'b101);
        vecs.push_back(mk(4'd13, 16'h0010, 16'h0, 16'h0, 3'd2, 16'h1234, 16'h0, 4'd5, 16'h1234, 1'b0, 6'd19));
        run_all();
        check("flags_hold", {29'h0, flags}, 32'b101);
`endif

        // Reset mid-run clears everything before any clock edge
        vecs.push_back(mk(4'd13, 16'h0010, 16'h0, 16'h0, 3'd0, 16'h1234, 16'h0, 4'd5, 16'h1234, 1'b0, 6'd19));
        run_all();
        @(negedge clk);
        #2;
        read_en = 4'd13; write_en = 16'h0810; im_rdata = 16'h5555;
        rst_n = 1'b0;
        #1;
        check("mid_rst_z", {16'h0, z}, 32'd1);
        check("mid_rst_dm_we", {31'h0, dm_we}, 32'd0);
        check("mid_rst_instr", {26'h0, instruction}, 32'd0);
        foreach (codes[i]) begin
            read_en = codes[i][3:0];
            #0.5;
            check($sformatf("mid_rst_code%0d", codes[i]), {16'h0, bus_dbg}, 32'd0);
        end
        read_en = 4'd13;
        @(posedge clk);
        #1;
        read_en = 4'd5;
        #1;
        check("rst_strobe_ignored", {16'h0, bus_dbg}, 32'd0);
`ifdef DATAPATH_FLAGS_EN
        check("rst_flags", {29'h0, flags}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1; read_en = 4'd13; write_en = 16'h0010;
        @(posedge clk);
        #1;
        idle_inputs();
        read_en = 4'd5;
        #1;
        check("post_rst_load", {16'h0, bus_dbg}, 32'h5555);
        check("post_rst_z", {16'h0, z}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/datapath_regs.md
Name: datapath_regs

Overview:
- Processor datapath that sits directly downstream of the microcoded control FSM. It consumes that FSM's outputs: read_en, write_en, inc_en, clr_en and alu_op.
- Holds the architectural registers PC, AR, IR, AC, R and R1-R4, plus a single shared bus multiplexer and the ALU.
- Drives instruction and data memory addresses, and returns the opcode and zero flag to the control FSM.
- Registers update on posedge clk; the control FSM changes state on negedge, so its outputs are stable at each posedge.

Parameters:
- DATA_W, 16, width of every register, the bus and the ALU.
- ADDR_W, 8, memory address width; im_addr = PC[ADDR_W-1:0], dm_addr = AR[ADDR_W-1:0].
- OPC_W, 6, opcode width; instruction = IR[OPC_W-1:0].

Ports:
- clk  in  1  system clock, rising-edge registers
- rst_n  in  1  asynchronous active-low reset
- read_en  in  4  bus source select
- write_en  in  16  per-target load strobes
- inc_en  in  16  per-target increment strobes
- clr_en  in  16  per-target clear strobes
- alu_op  in  3  ALU function
- im_rdata  in  DATA_W  instruction memory read data
- dm_rdata  in  DATA_W  data memory read data
- im_addr  out  ADDR_W  instruction memory address
- dm_addr  out  ADDR_W  data memory address
- dm_wdata  out  DATA_W  data memory write data (= AC)
- dm_we  out  1  data memory write strobe
- instruction  out  OPC_W  opcode to control
- z  out  16  zero flag to control; 16'd1 when AC==0, else 16'd0
- bus_dbg  out  DATA_W  current bus value

Behaviour:
- Reset: asynchronous on rst_n low. Clears PC, AR, IR, AC, R, R1-R4 (and the flag register, when the optional feature is compiled in). Outputs at reset: z=1, dm_we=0, instruction=0.
- Bus mux, combinational on read_en:
  - 1 = PC, 2 = AR, 4 = IR, 5 = AC, 6 = R
  - 7 = R1, 8 = R2, 9 = R3, 10 = R4
  - 12 = dm_rdata, 13 = im_rdata
  - All other codes (0, 3, 11, 14, 15) drive 0.
- Strobe bit map, shared by write_en, inc_en and clr_en:
  - bit1 PC, bit2 AR, bit3 IR, bit4 AC, bit5 R
  - bit7 R4, bit8 R3, bit9 R2, bit10 R1
  - bit11 DM write (write_en only), bit12 ALU->AC (write_en only)
  - Bits 0, 6, 13, 14 and 15 are ignored.
- Per-register priority at posedge: clr > write > inc > hold.
  - Write loads bus[DATA_W-1:0].
  - Inc adds 1 modulo 2^DATA_W; 0xFFFF wraps to 0x0000.
  - Write and inc on the same register in the same cycle: write wins, no increment.
- AC sources: write_en[12] loads alu_out.
  - If write_en[4] and write_en[12] are both set, write_en[12] wins.
  - clr_en[4] overrides both.
  - inc_en[4] applies only when neither AC write bit is set.
- ALU, combinational, result truncated to DATA_W:
  - 1: AC+R
  - 2: AC-R
  - 3: low half of AC*R
  - 4: AC<<1, zero-filled
  - others: AC passthrough
- dm_we = write_en[11], combinational (not registered). The memory samples dm_addr, dm_wdata and dm_we at posedge.
- IR is loaded in full width; instruction is a combinational slice of IR.
- Latency: a register written at posedge N is visible on the bus and outputs after that edge. z therefore reflects the new AC before the next negedge state update.
- Reset asserted mid-operation clears all registers immediately. Strobes are ignored while rst_n is low. The first posedge after deassertion behaves normally.

Optional Feature:
- Macro: DATAPATH_FLAGS_EN.
- When defined, adds output flags[2:0] = {carry, overflow, negative}. It is a register updated only on cycles where write_en[12] is set:
  - carry = bit DATA_W of the AC+R or AC-R unsigned result (borrow for sub), 0 for other ops.
  - overflow = signed overflow of add/sub, 0 for other ops.
  - negative = MSB of the new AC.
  - Reset value 0.
- When undefined, the port and the register are absent and behaviour is otherwise identical.

Test Plan:
- Reset: rst_n low mid-run with AC=0x1234 -> all registers 0, z=1, dm_we=0 immediately, before any clk edge.
- Fetch: im_rdata=0x0013, read_en=13, write_en bit3 -> instruction=6'd19 after posedge.
- Add: AC=0x0005, R=0x0003, alu_op=1, write_en bit12 -> AC=0x0008, z=0. Sub with AC=R=0x0007 -> AC=0x0000, z=1.
- Increment wrap: PC=0xFFFF, inc_en bit1 -> PC=0x0000. Same cycle with write_en bit1 and bus=0x0040 -> PC=0x0040, not 0x0041.
- Priority and store: clr_en bit4 with write_en bit4 -> AC=0. AR=0x0010, AC=0x00AA, write_en bit11 -> dm_addr=0x10, dm_wdata=0x00AA, dm_we=1 for exactly that cycle.
- Flags (DATAPATH_FLAGS_EN): AC=0x7FFF, R=1, add -> AC=0x8000, flags=3'b011.
